// File: rtl/iq_acc_pkg.sv
// Shared definitions for the I/Q readout-window integrator.
//   SAMPLE_W / ACC_W : default sample and per-channel accumulator widths
//   state_e          : readout sequencer states
//   I_HALF / Q_HALF  : which ACC_W-wide half of accumulated_data carries each channel
package iq_acc_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned ACC_W    = 32;

    // I sum occupies the upper half of the output bus, Q the lower half.
    localparam int unsigned I_HALF = 1;
    localparam int unsigned Q_HALF = 0;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StAccum,
        StEmit
    } state_e;

endpackage

// File: rtl/iq_accum_lane.sv
// One signed clear/enable accumulator lane.
//   clk, rst   : clock, asynchronous active-low reset
//   clr        : zero the running sum (wins over en)
//   en         : add the sign-extended sample
//   sample     : signed input sample, IN_W bits
//   sum_next   : value the running sum takes at the next rising edge
// The top captures sum_next into its output register on the cycle the final
// sample is added, so the result is visible in the very next cycle.
module iq_accum_lane #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [IN_W-1:0]  sample,
    output logic signed [ACC_W-1:0] sum_next
);

    logic signed [ACC_W-1:0] sum_q;

    always_comb begin
        sum_next = sum_q;
        if (clr) begin
            sum_next = '0;
        end else if (en) begin
            sum_next = sum_q + ACC_W'(sample);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_next;
        end
    end

endmodule

// File: rtl/iq_accumulator.sv
// Readout-window integrator: after an accepted trigger, discards delay_len valid
// samples, sums the next window_len valid I/Q samples, then emits both sums with
// a one-cycle start_trigger pulse.
//   clk, rst          : clock, asynchronous active-low reset
//   readout_trigger   : start request (accepted in idle or emit, ignored otherwise)
//   delay_len         : valid samples to discard, latched on accept
//   window_len        : valid samples to sum, latched on accept
//   sample_valid      : sample_i / sample_q valid this cycle
//   sample_i/sample_q : signed samples
//   missed_clr        : clears trig_missed (an ignored trigger in the same cycle wins)
//   accumulated_data  : {I_sum, Q_sum}, held between emits
//   start_trigger     : one-cycle result pulse
//   busy              : readout in progress (armed, accumulating or emitting)
//   trig_missed       : sticky ignored-trigger flag
//   frame_count       : number of results emitted, wrapping
module iq_accumulator #(
    parameter int unsigned SAMPLE_W = iq_acc_pkg::SAMPLE_W,
    parameter int unsigned ACC_W    = iq_acc_pkg::ACC_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   readout_trigger,
    input  logic [15:0]            delay_len,
    input  logic [15:0]            window_len,
    input  logic                   sample_valid,
    input  logic [SAMPLE_W-1:0]    sample_i,
    input  logic [SAMPLE_W-1:0]    sample_q,
    input  logic                   missed_clr,
    output logic [2*ACC_W-1:0]     accumulated_data,
    output logic                   start_trigger,
    output logic                   busy,
    output logic                   trig_missed,
    output logic [15:0]            frame_count
);

    import iq_acc_pkg::*;

    state_e                  state_q, state_d;
    logic [15:0]             delay_cnt_q, delay_cnt_d;
    logic [15:0]             win_cnt_q, win_cnt_d;
    logic [2*ACC_W-1:0]      acc_data_q;
    logic                    start_trigger_q;
    logic                    trig_missed_q;
    logic [15:0]             frame_count_q;
    logic                    lane_clr, lane_en, trig_ignored;
    logic signed [ACC_W-1:0] i_next, q_next;

    always_comb begin
        state_d      = state_q;
        delay_cnt_d  = delay_cnt_q;
        win_cnt_d    = win_cnt_q;
        lane_clr     = 1'b0;
        lane_en      = 1'b0;
        trig_ignored = 1'b0;
        unique case (state_q)
            StIdle, StEmit: begin
                state_d = StIdle;
                if (readout_trigger) begin
                    lane_clr    = 1'b1;
                    delay_cnt_d = delay_len;
                    win_cnt_d   = window_len;
                    if (delay_len != 16'd0) begin
                        state_d = StArmed;
                    end else if (window_len != 16'd0) begin
                        state_d = StAccum;
                    end else begin
                        state_d = StEmit;
                    end
                end
            end
            StArmed: begin
                trig_ignored = readout_trigger;
                if (sample_valid) begin
                    delay_cnt_d = delay_cnt_q - 16'd1;
                    if (delay_cnt_q == 16'd1) begin
                        state_d = (win_cnt_q != 16'd0) ? StAccum : StEmit;
                    end
                end
            end
            StAccum: begin
                trig_ignored = readout_trigger;
                if (sample_valid) begin
                    lane_en   = 1'b1;
                    win_cnt_d = win_cnt_q - 16'd1;
                    if (win_cnt_q == 16'd1) begin
                        state_d = StEmit;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    iq_accum_lane #(
        .IN_W  (SAMPLE_W),
        .ACC_W (ACC_W)
    ) u_lane_i (
        .clk      (clk),
        .rst      (rst),
        .clr      (lane_clr),
        .en       (lane_en),
        .sample   (sample_i),
        .sum_next (i_next)
    );

    iq_accum_lane #(
        .IN_W  (SAMPLE_W),
        .ACC_W (ACC_W)
    ) u_lane_q (
        .clk      (clk),
        .rst      (rst),
        .clr      (lane_clr),
        .en       (lane_en),
        .sample   (sample_q),
        .sum_next (q_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StIdle;
            delay_cnt_q     <= '0;
            win_cnt_q       <= '0;
            acc_data_q      <= '0;
            start_trigger_q <= 1'b0;
            trig_missed_q   <= 1'b0;
            frame_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            delay_cnt_q     <= delay_cnt_d;
            win_cnt_q       <= win_cnt_d;
            start_trigger_q <= (state_d == StEmit);
            // Output register loads only on entry to (or re-entry of) the emit
            // state, so mid-window sums never reach accumulated_data.
            if (state_d == StEmit) begin
                acc_data_q[I_HALF*ACC_W +: ACC_W] <= i_next;
                acc_data_q[Q_HALF*ACC_W +: ACC_W] <= q_next;
                frame_count_q                     <= frame_count_q + 16'd1;
            end
            if (trig_ignored) begin
                trig_missed_q <= 1'b1;
            end else if (missed_clr) begin
                trig_missed_q <= 1'b0;
            end
        end
    end

    assign accumulated_data = acc_data_q;
    assign start_trigger    = start_trigger_q;
    assign busy             = (state_q != StIdle);
    assign trig_missed      = trig_missed_q;
    assign frame_count      = frame_count_q;

endmodule

// File: tb/tb_iq_accumulator.sv
// Self-checking bench for iq_accumulator: directed vector table, hand-written
// corner sequences and randomized readouts checked against a window-sum model.
module tb_iq_accumulator;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               readout_trigger = 1'b0;
    logic [15:0]        delay_len = '0;
    logic [15:0]        window_len = '0;
    logic               sample_valid = 1'b0;
    logic signed [15:0] sample_i = '0;
    logic signed [15:0] sample_q = '0;
    logic               missed_clr = 1'b0;
    logic [63:0]        accumulated_data;
    logic               start_trigger;
    logic               busy;
    logic               trig_missed;
    logic [15:0]        frame_count;

    int          n_checks = 0;
    int          n_pass = 0;
    int          model_fc = 0;
    bit          model_missed = 0;
    logic [63:0] model_data = '0;

    always #5 clk = ~clk;

    iq_accumulator dut (
        .clk              (clk),
        .rst              (rst),
        .readout_trigger  (readout_trigger),
        .delay_len        (delay_len),
        .window_len       (window_len),
        .sample_valid     (sample_valid),
        .sample_i         (sample_i),
        .sample_q         (sample_q),
        .missed_clr       (missed_clr),
        .accumulated_data (accumulated_data),
        .start_trigger    (start_trigger),
        .busy             (busy),
        .trig_missed      (trig_missed),
        .frame_count      (frame_count)
    );

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        readout_trigger = 1'b0;
        sample_valid    = 1'b0;
        missed_clr      = 1'b0;
    endtask

    task automatic step(input bit trig, input bit clr, input bit v,
                        input logic signed [15:0] i, input logic signed [15:0] q);
        readout_trigger = trig;
        missed_clr      = clr;
        sample_valid    = v;
        sample_i        = i;
        sample_q        = q;
        tick();
        idle_inputs();
    endtask

    // One complete readout: expected sums come from counting valid samples and
    // adding those whose index falls in [d, d+w).
    task automatic readout(input int d, input int w, input int gap_pct, input int inj_pct,
                           input bit rnd, input logic signed [15:0] ci,
                           input logic signed [15:0] cq, input string tag, output int lat);
        longint             ei, eq;
        int                 n;
        bit                 bad_mid;
        logic signed [15:0] si, sq;
        ei = 0; eq = 0; n = 0; bad_mid = 0;
        delay_len       = 16'(d);
        window_len      = 16'(w);
        readout_trigger = 1'b1;
        missed_clr      = 1'b0;
        // A valid sample in the trigger cycle must not be counted.
        sample_valid    = 1'b1;
        sample_i        = 16'sh4321;
        sample_q        = -16'sh1234;
        tick();
        lat = 1;
        readout_trigger = 1'b0;
        delay_len       = 16'($urandom);
        window_len      = 16'($urandom);
        while (n < d + w) begin
            if (start_trigger || !busy) bad_mid = 1;
            sample_valid = ($urandom_range(99) >= gap_pct);
            if (rnd) begin
                si = 16'($urandom);
                sq = 16'($urandom);
            end else begin
                si = ci;
                sq = cq;
            end
            sample_i        = si;
            sample_q        = sq;
            readout_trigger = ($urandom_range(99) < inj_pct);
            missed_clr      = ($urandom_range(99) < inj_pct);
            if (readout_trigger) model_missed = 1;
            else if (missed_clr) model_missed = 0;
            if (sample_valid) begin
                if (n >= d) begin
                    ei += si;
                    eq += sq;
                end
                n++;
            end
            tick();
            lat++;
        end
        idle_inputs();
        model_fc   = (model_fc + 1) & 16'hFFFF;
        model_data = {ei[31:0], eq[31:0]};
        check({tag, " pulse"}, start_trigger, 1);
        check({tag, " data"}, accumulated_data, model_data);
        check({tag, " frame_count"}, frame_count, model_fc);
        check({tag, " no early pulse"}, bad_mid, 0);
        check({tag, " trig_missed"}, trig_missed, model_missed);
        check({tag, " busy in emit"}, busy, 1);
        tick();
        check({tag, " pulse width"}, start_trigger, 0);
        check({tag, " idle after"}, busy, 0);
        check({tag, " data held"}, accumulated_data, model_data);
    endtask

    typedef struct {
        int                 d;
        int                 w;
        logic signed [15:0] si;
        logic signed [15:0] sq;
        logic [31:0]        exp_i;
        logic [31:0]        exp_q;
        int                 exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat;

        vecs[0] = '{0, 0, 16'sd5,     16'sd5,      32'd0,          32'd0,          1};
        vecs[1] = '{0, 1, 16'sd3,     -16'sd2,     32'd3,          32'hFFFF_FFFE,  2};
        vecs[2] = '{3, 2, -16'sd7,    16'sd100,    32'hFFFF_FFF2,  32'd200,        6};
        vecs[3] = '{1, 0, 16'sd9,     16'sd9,      32'd0,          32'd0,          2};
        vecs[4] = '{0, 5, 16'sd32767, -16'sd32768, 32'd163835,     32'hFFFD_8000,  6};
        vecs[5] = '{2, 3, -16'sd1,    16'sd1,      32'hFFFF_FFFD,  32'd3,          6};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset data", accumulated_data, 0);
        check("reset start_trigger", start_trigger, 0);
        check("reset busy", busy, 0);
        check("reset trig_missed", trig_missed, 0);
        check("reset frame_count", frame_count, 0);
        rst = 1'b1;
        tick();

        // delay 2, window 4, I = 1..4, Q = -1, with gaps
        delay_len = 16'd2;
        window_len = 16'd4;
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 16'sd100, 16'sd100);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, -16'sd50, 16'sd77);
        step(0, 0, 1, 16'sd1, -16'sd1);
        step(0, 0, 1, 16'sd2, -16'sd1);
        step(0, 0, 0, 16'sd9, 16'sd9);
        step(0, 0, 1, 16'sd3, -16'sd1);
        check("basic no early pulse", start_trigger, 0);
        step(0, 0, 1, 16'sd4, -16'sd1);
        check("basic pulse", start_trigger, 1);
        check("basic data", accumulated_data, {32'd10, 32'hFFFF_FFFC});
        check("basic frame_count", frame_count, 16'd1);
        model_fc = 1;
        model_data = {32'd10, 32'hFFFF_FFFC};
        step(0, 0, 0, 0, 0);
        check("basic pulse one cycle", start_trigger, 0);

        // Directed table, gap-free
        foreach (vecs[k]) begin
            readout(vecs[k].d, vecs[k].w, 0, 0, 0, vecs[k].si, vecs[k].sq,
                    $sformatf("vec%0d", k), lat);
            check($sformatf("vec%0d const data", k), model_data, {vecs[k].exp_i, vecs[k].exp_q});
            check($sformatf("vec%0d latency", k), lat, vecs[k].exp_lat);
        end

        // Ignored trigger, clear, and simultaneous set+clear
        delay_len = 16'd0;
        window_len = 16'd3;
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 16'sd2, 16'sd3);
        step(1, 0, 0, 0, 0);
        check("miss set", trig_missed, 1);
        check("miss keeps busy", busy, 1);
        step(0, 0, 1, 16'sd2, 16'sd3);
        step(0, 0, 1, 16'sd2, 16'sd3);
        check("miss pulse", start_trigger, 1);
        check("miss sums unchanged", accumulated_data, {32'd6, 32'd9});
        model_fc = (model_fc + 1) & 16'hFFFF;
        step(0, 1, 0, 0, 0);
        check("miss clear", trig_missed, 0);
        window_len = 16'd2;
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 16'sd4, 16'sd4);
        check("miss set beats clear", trig_missed, 1);
        step(0, 0, 1, 16'sd4, 16'sd4);
        check("miss2 data", accumulated_data, {32'd8, 32'd8});
        model_fc = (model_fc + 1) & 16'hFFFF;
        step(0, 1, 0, 0, 0);
        model_missed = 0;

        // Back-to-back: trigger during emit, window 1
        delay_len = 16'd0;
        window_len = 16'd1;
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 16'sd5, 16'sd5);
        check("b2b first pulse", start_trigger, 1);
        check("b2b first data", accumulated_data, {32'd5, 32'd5});
        step(1, 0, 1, 16'sd99, 16'sd99);
        check("b2b busy between", busy, 1);
        check("b2b gap no pulse", start_trigger, 0);
        step(0, 0, 1, 16'sd7, 16'sd7);
        check("b2b second pulse", start_trigger, 1);
        check("b2b second data", accumulated_data, {32'd7, 32'd7});
        model_fc = (model_fc + 2) & 16'hFFFF;
        check("b2b frame_count", frame_count, model_fc);
        step(0, 0, 0, 0, 0);
        check("b2b idle", busy, 0);

        // Reset mid-window (with a sticky miss pending)
        window_len = 16'd10;
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 16'sd1000, 16'sd1000);
        step(1, 0, 1, 16'sd1000, 16'sd1000);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort data", accumulated_data, 0);
        check("abort start_trigger", start_trigger, 0);
        check("abort busy", busy, 0);
        check("abort trig_missed", trig_missed, 0);
        check("abort frame_count", frame_count, 0);
        tick();
        rst = 1'b1;
        tick();
        check("abort no late pulse", start_trigger, 0);
        model_fc = 0;
        model_missed = 0;
        readout(1, 3, 30, 0, 1, 0, 0, "post-reset", lat);

        // frame_count wrap, also the minimum-latency case
        force dut.frame_count_q = 16'hFFFF;
        #1;
        release dut.frame_count_q;
        model_fc = 16'hFFFF;
        readout(0, 0, 0, 0, 0, 0, 0, "wrap", lat);
        check("wrap frame_count", frame_count, 16'h0000);
        check("wrap latency", lat, 1);
        check("wrap zero data", accumulated_data, 0);

        // Longest window at full-scale inputs
        readout(0, 65535, 0, 0, 0, 16'sh7FFF, 16'sh8000, "win65535", lat);
        check("win65535 I", accumulated_data[63:32], 32'h7FFE_8001);
        check("win65535 Q", accumulated_data[31:0], 32'h8000_8000);
        check("win65535 latency", lat, 65536);

        // Randomized readouts with gaps, ignored triggers and clears
        for (int r = 0; r < 40; r++) begin
            readout($urandom_range(6), $urandom_range(20), $urandom_range(60), 10, 1, 0, 0,
                    $sformatf("rand%0d", r), lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
